gcd_job_dispatcher: RTL
=======================

# gcd_job_dispatcher

Operand front end for the `gcd` unit. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It sequences each pair into `gcd` using the `start`/`done` protocol and returns `{a, b, gcd}` on a valid/ready result stream. It also short-circuits zero operands and flags hung jobs with a timeout, so upstream producers never talk to `gcd` directly.

## Interface
Parameters:
- `WIDTH`, 32 — operand/result width.
- `DEPTH`, 4 — input FIFO entries; must be a power of 2 and ≥2.
- `GAP_CYCLES`, 2 — idle cycles enforced after each result is accepted, before the next `gcd_start`.
- `TIMEOUT`, 1024 — maximum WAIT cycles before a job is aborted.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1 — single clock.
  - `reset_n` in 1 — asynchronous, active-low reset.
- Input stream:
  - `in_valid` in 1, `in_ready` out 1 — input handshake.
  - `in_a`, `in_b` in WIDTH — operand pair.
- Result stream:
  - `out_valid` out 1, `out_ready` in 1 — result handshake.
  - `out_a`, `out_b` out WIDTH — echoed operands.
  - `out_gcd` out WIDTH — result.
  - `out_err` out 1 — job timed out.
- `gcd` side:
  - `gcd_start` out 1 — one-cycle start pulse.
  - `gcd_a`, `gcd_b` out WIDTH — operands to `gcd`.
  - `gcd_done` in 1, `gcd_result` in WIDTH — completion and result from `gcd`.
- Status:
  - `busy` out 1 — state ≠ IDLE or FIFO non-empty.
  - `fifo_count` out $clog2(DEPTH+1) — FIFO occupancy.

## Operation
- **Reset:** all outputs are 0, the FIFO is empty and the state is IDLE. `in_ready` rises on the first clock after reset release.
- **Input handshake:**
  - A push happens on an edge where `in_valid && in_ready`.
  - `in_ready = (fifo_count != DEPTH)`, driven from registered count only. There is no pop-through when full.
- **FSM states:** IDLE, ISSUE, WAIT, HOLD, GAP.
- **IDLE:**
  - When the FIFO is non-empty: pop into the operand register.
  - If either operand is 0, go to HOLD (bypass) with `out_gcd = a | b`. This gives gcd(x,0)=x and gcd(0,0)=0.
  - Otherwise go to ISSUE.
- **ISSUE:** `gcd_start=1` for exactly this cycle, then WAIT. `gcd_done` is ignored in this cycle.
- **WAIT:**
  - On the first edge with `gcd_done=1`: capture `gcd_result` into `out_gcd`, set `out_err=0`, go to HOLD.
  - The timeout counter increments each WAIT cycle. After TIMEOUT cycles without done: `out_gcd=0`, `out_err=1`, go to HOLD.
- **HOLD:** `out_valid=1`. The edge with `out_ready=1` completes the transfer.
  - If `GAP_CYCLES=0`, go to IDLE; otherwise go to GAP.
- **GAP:** count `GAP_CYCLES` cycles, then IDLE.
- **`gcd_a`/`gcd_b`:** driven from the operand register. They are stable from ISSUE through WAIT and hold their last value elsewhere (never X).
- **`out_a`/`out_b`/`out_gcd`/`out_err`:** stable while `out_valid && !out_ready`.
- **Ordering:** results leave in input order, one job in flight.
- **FIFO concurrency:** FIFO push and pop may occur on the same edge when the FIFO is neither full nor empty. A pop never occurs from an empty FIFO.
- **Asynchronous reset mid-operation:** state, FIFO and counters clear immediately; `gcd_start`, `out_valid` and `busy` drop without waiting for a clock. The job in flight is discarded. `gcd` shares `reset_n`.

## Timing
Edge k is the push edge, into an empty FIFO with the FSM in IDLE.
- Edge k+1: pop; enter ISSUE (or HOLD on bypass).
- Normal path:
  - `gcd_start` is high in the cycle after edge k+1.
  - WAIT begins at edge k+2.
  - Result capture happens at the first WAIT edge with `gcd_done`; `out_valid` is high the following cycle.
- Bypass path: `out_valid` is high in the cycle after edge k+1, i.e. 2 cycles after acceptance.
- Minimum spacing between consecutive `gcd_start` pulses is 3 + `GAP_CYCLES` + (WAIT length) cycles.
- Timeout: abort after exactly TIMEOUT WAIT cycles; `out_valid` is high the next cycle.

## Structure
- Package `gcd_pkg`: `GCD_W = 32` constant and `dispatch_state_t` enum (IDLE, ISSUE, WAIT, HOLD, GAP). It is shared with the `gcd` bench covergroups.
- Sub-module `gcd_op_fifo`: synchronous FIFO, 2·WIDTH wide, DEPTH deep, with count output and full/empty derived from count.
- The top level holds the FSM, operand register, result register, timeout counter and gap counter.

## Test plan
The bench uses a behavioral `gcd` model with configurable done latency.
- **Basic job:** push (12,18), `out_ready=1`, model done after 5 cycles with 6 → `out_a=12`, `out_b=18`, `out_gcd=6`, `out_err=0`. `gcd_start` is high for exactly one cycle, 2 cycles after acceptance.
- **Bypass:** push (0,35) then (0,0) → results 35 then 0, each `out_valid` 2 cycles after acceptance, and `gcd_start` is never asserted.
- **FIFO fill:** `DEPTH=4`, push 6 pairs back-to-back while the first is in WAIT → `in_ready` drops at `fifo_count=4`. All 6 results come out in order, and consecutive `gcd_start` pulses are ≥ `GAP_CYCLES`+3 apart.
- **Backpressure:** hold `out_ready=0` for 10 cycles on result (48,36,12) → `out_*` stay stable and no new `gcd_start` occurs until the transfer; then GAP, then the next issue.
- **Timeout:** `TIMEOUT=16`, model never asserts done → `out_err=1` and `out_gcd=0` after 16 WAIT cycles. The following job (9,6) returns 3 with `out_err=0`.
- **Reset mid-operation:** assert `reset_n=0` mid-WAIT with 3 entries queued → `gcd_start`, `out_valid`, `busy` and `fifo_count` are 0 before the next edge. After release, `in_ready=1` and no stale result appears.

Source files
------------

// File: rtl/gcd_pkg.sv
// Definitions shared by the gcd job dispatcher and the gcd bench covergroups.
package gcd_pkg;

  localparam int GCD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    GAP
  } dispatch_state_t;

endpackage

// File: rtl/gcd_op_fifo.sv
// Synchronous operand-pair FIFO; full/empty are decoded from the occupancy count.
module gcd_op_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == FULL_COUNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage is left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/gcd_job_dispatcher.sv
// Buffers operand pairs, runs them one at a time through gcd, and returns
// {a, b, gcd} results with zero-operand bypass and a WAIT timeout.
module gcd_job_dispatcher
  import gcd_pkg::*;
#(
  parameter int WIDTH      = GCD_W,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic [WIDTH-1:0]           out_gcd,
  output logic                       out_err,
  output logic                       gcd_start,
  output logic [WIDTH-1:0]           gcd_a,
  output logic [WIDTH-1:0]           gcd_b,
  input  logic                       gcd_done,
  input  logic [WIDTH-1:0]           gcd_result,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  dispatch_state_t    state_reg;
  dispatch_state_t    state_next;
  logic               init_reg;
  logic [WIDTH-1:0]   op_a_reg;
  logic [WIDTH-1:0]   op_b_reg;
  logic [WIDTH-1:0]   res_gcd_reg;
  logic               res_err_reg;
  logic [TW-1:0]      timer_reg;
  logic [GW-1:0]      gap_cnt_reg;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] fifo_rd_data;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic               timed_out;

  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;
  assign head_a    = fifo_rd_data[2*WIDTH-1:WIDTH];
  assign head_b    = fifo_rd_data[WIDTH-1:0];
  assign timed_out = !gcd_done && (timer_reg == TIMER_LAST);

  gcd_op_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!fifo_empty) state_next = (head_a == '0 || head_b == '0) ? HOLD : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (gcd_done || timed_out) state_next = HOLD;
      HOLD:    if (out_ready) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // init_reg keeps in_ready low until the first edge after reset release.
  always_comb begin
    gcd_start = (state_reg == ISSUE);
    out_valid = (state_reg == HOLD);
    busy      = (state_reg != IDLE) || !fifo_empty;
    in_ready  = init_reg && !fifo_full;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_reg    <= 1'b0;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      res_gcd_reg <= '0;
      res_err_reg <= 1'b0;
      timer_reg   <= '0;
      gap_cnt_reg <= '0;
    end else begin
      init_reg <= 1'b1;
      case (state_reg)
        // Result is preloaded with a|b, which is already the answer on bypass.
        IDLE: if (!fifo_empty) begin
          op_a_reg    <= head_a;
          op_b_reg    <= head_b;
          res_gcd_reg <= head_a | head_b;
          res_err_reg <= 1'b0;
        end
        ISSUE: timer_reg <= '0;
        WAIT: begin
          if (gcd_done) begin
            res_gcd_reg <= gcd_result;
            res_err_reg <= 1'b0;
          end else if (timed_out) begin
            res_gcd_reg <= '0;
            res_err_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        HOLD:    gap_cnt_reg <= '0;
        GAP:     gap_cnt_reg <= gap_cnt_reg + 1'b1;
        default: ;
      endcase
    end
  end

  assign gcd_a   = op_a_reg;
  assign gcd_b   = op_b_reg;
  assign out_a   = op_a_reg;
  assign out_b   = op_b_reg;
  assign out_gcd = res_gcd_reg;
  assign out_err = res_err_reg;

endmodule
